// File: rtl/vscale_hasti_sram_slave_pkg.sv
// Shared HASTI bus widths, transfer/response/size codes and the byte-lane helper
// used by the SRAM responder.
package vscale_hasti_sram_slave_pkg;

    localparam int HASTI_ADDR_WIDTH  = 32;
    localparam int HASTI_BUS_WIDTH   = 32;
    localparam int HASTI_SIZE_WIDTH  = 3;
    localparam int HASTI_BURST_WIDTH = 3;
    localparam int HASTI_PROT_WIDTH  = 4;
    localparam int HASTI_TRANS_WIDTH = 2;
    localparam int HASTI_RESP_WIDTH  = 1;

    localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_IDLE   = 2'b00;
    localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_BUSY   = 2'b01;
    localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_NONSEQ = 2'b10;
    localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_SEQ    = 2'b11;

    localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_OKAY  = 1'b0;
    localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_ERROR = 1'b1;

    localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_BYTE = 3'd0;
    localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_HALF = 3'd1;
    localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_WORD = 3'd2;

    typedef struct packed {
        logic [HASTI_ADDR_WIDTH-1:0] addr;
        logic                        write;
        logic [HASTI_SIZE_WIDTH-1:0] size;
    } hasti_phase_t;

    // Only called for transfers that already passed the alignment check.
    function automatic logic [3:0] byte_lanes(input logic [HASTI_SIZE_WIDTH-1:0] size,
                                              input logic [1:0] addr);
        logic [3:0] lanes;
        case (size)
            HASTI_SIZE_BYTE: lanes = 4'b0001 << addr;
            HASTI_SIZE_HALF: lanes = addr[1] ? 4'b1100 : 4'b0011;
            default:         lanes = 4'b1111;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/vscale_sram_array.sv
// NWORDS x 32-bit storage: combinational read, byte-enabled synchronous write,
// contents deliberately not reset.
module vscale_sram_array #(
    parameter int unsigned NWORDS = 1024,
    parameter int unsigned IDX_W  = 10
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [3:0]       i_be,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [NWORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_be[b]) begin
                r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/vscale_hasti_sram_slave.sv
// HASTI single-port SRAM responder with OKAY/two-cycle ERROR responses.
// Wait states are honoured only when VSCALE_HASTI_SRAM_WAIT_EN is defined.
module vscale_hasti_sram_slave
    import vscale_hasti_sram_slave_pkg::*;
#(
    parameter int unsigned NWORDS      = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [HASTI_ADDR_WIDTH-1:0]  haddr,
    input  logic                         hwrite,
    input  logic [HASTI_SIZE_WIDTH-1:0]  hsize,
    input  logic [HASTI_BURST_WIDTH-1:0] hburst,
    input  logic                         hmastlock,
    input  logic [HASTI_PROT_WIDTH-1:0]  hprot,
    input  logic [HASTI_TRANS_WIDTH-1:0] htrans,
    input  logic [HASTI_BUS_WIDTH-1:0]   hwdata,
    output logic [HASTI_BUS_WIDTH-1:0]   hrdata,
    output logic                         hready,
    output logic [HASTI_RESP_WIDTH-1:0]  hresp
);

    localparam int unsigned IdxW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [32:0] Span = 33'(NWORDS) << 2;

    typedef enum logic [1:0] {StIdle, StData, StErr1, StErr2} state_e;

    state_e       r_state;
    state_e       w_state_next;
    hasti_phase_t r_phase;

    logic            w_ready;
    logic            w_accept;
    logic            w_bad;
    logic            w_misaligned;
    logic            w_cnt_zero;
    logic [32:0]     w_haddr_off;
    logic [31:0]     w_off;
    logic [IdxW-1:0] w_idx;
    logic [3:0]      w_be;
    logic [31:0]     w_rdata;
    logic            w_unused;

    // An address below BASE_ADDR borrows into bit 32, so one compare covers both bounds.
    assign w_haddr_off = {1'b0, haddr} - {1'b0, BASE_ADDR};

    always_comb begin
        w_misaligned = 1'b1;
        case (hsize)
            HASTI_SIZE_BYTE: w_misaligned = 1'b0;
            HASTI_SIZE_HALF: w_misaligned = haddr[0];
            HASTI_SIZE_WORD: w_misaligned = |haddr[1:0];
            default:         w_misaligned = 1'b1;
        endcase
    end

    assign w_bad    = (w_haddr_off >= Span) || w_misaligned;
    assign w_accept = w_ready && ((htrans == HASTI_TRANS_NONSEQ) || (htrans == HASTI_TRANS_SEQ));

`ifdef VSCALE_HASTI_SRAM_WAIT_EN
    logic [3:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 4'd0;
        end else if (w_accept && !w_bad) begin
            r_cnt <= 4'(WAIT_STATES);
        end else if (r_state == StData && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign w_cnt_zero = (r_cnt == 4'd0);
`else
    logic [3:0] w_unused_wait;

    assign w_unused_wait = 4'(WAIT_STATES);
    assign w_cnt_zero    = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ERR2 and the last DATA cycle complete like IDLE and may take the next address phase.
    always_comb begin
        w_state_next = r_state;
        if (r_state == StErr1) begin
            w_state_next = StErr2;
        end else if (w_ready) begin
            if (w_accept) begin
                w_state_next = w_bad ? StErr1 : StData;
            end else begin
                w_state_next = StIdle;
            end
        end
    end

    always_comb begin
        w_ready = 1'b1;
        hresp   = HASTI_RESP_OKAY;
        unique case (r_state)
            StIdle: ;
            StData: w_ready = w_cnt_zero;
            StErr1: begin
                w_ready = 1'b0;
                hresp   = HASTI_RESP_ERROR;
            end
            StErr2: hresp = HASTI_RESP_ERROR;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= '0;
        end else if (w_accept) begin
            r_phase <= '{addr: haddr, write: hwrite, size: hsize};
        end
    end

    assign w_off = r_phase.addr - BASE_ADDR;
    assign w_idx = w_off[IdxW+1:2];
    assign w_be  = (r_state == StData && w_ready && r_phase.write)
                 ? byte_lanes(r_phase.size, r_phase.addr[1:0]) : 4'b0000;

    vscale_sram_array #(
        .NWORDS (NWORDS),
        .IDX_W  (IdxW)
    ) u_array (
        .clk     (clk),
        .i_idx   (w_idx),
        .i_be    (w_be),
        .i_wdata (hwdata),
        .o_rdata (w_rdata)
    );

    assign hready = w_ready;
    assign hrdata = (r_state == StData && w_ready && !r_phase.write) ? w_rdata : '0;

    assign w_unused = ^{hburst, hmastlock, hprot, w_off[31:IdxW+2], w_off[1:0]};

endmodule

// File: tb/tb_vscale_hasti_sram_slave.sv
// Randomized bench for vscale_hasti_sram_slave against a byte-level memory and
// transfer-timeline reference model.
module tb_vscale_hasti_sram_slave;
    import vscale_hasti_sram_slave_pkg::*;

    localparam int unsigned NWORDS = 64;
    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam int unsigned NBYTES = NWORDS * 4;
`ifdef VSCALE_HASTI_SRAM_WAIT_EN
    localparam int unsigned WAITS = 2;
`else
    localparam int unsigned WAITS = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] haddr = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = '0;
    logic [2:0]  hburst = '0;
    logic        hmastlock = 1'b0;
    logic [3:0]  hprot = '0;
    logic [1:0]  htrans = HASTI_TRANS_IDLE;
    logic [31:0] hwdata = '0;
    logic [31:0] hrdata;
    logic        hready;
    logic [0:0]  hresp;

    vscale_hasti_sram_slave #(
        .NWORDS      (NWORDS),
        .BASE_ADDR   (BASE),
        .WAIT_STATES (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hburst    (hburst),
        .hmastlock (hmastlock),
        .hprot     (hprot),
        .htrans    (htrans),
        .hwdata    (hwdata),
        .hrdata    (hrdata),
        .hready    (hready),
        .hresp     (hresp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    xfer_t      q[$];
    logic [7:0] mem_m [NBYTES];
    bit         p_valid;
    bit         p_bad;
    int         p_left;
    xfer_t      p;
    int         n_checks;
    int         n_errors;
    int         cyc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_bad(input xfer_t x);
        longint a = longint'(x.addr);
        if (a < longint'(BASE) || a >= longint'(BASE) + longint'(NBYTES)) return 1'b1;
        if (x.size > 3'd2) return 1'b1;
        if (x.size == 3'd1 && x.addr[0]) return 1'b1;
        if (x.size == 3'd2 && x.addr[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] addr);
        int w = int'((addr - BASE) & 32'hFFFF_FFFC);
        return {mem_m[w+3], mem_m[w+2], mem_m[w+1], mem_m[w]};
    endfunction

    task automatic apply_write(input xfer_t x);
        int off = int'(x.addr - BASE);
        for (int i = 0; i < (1 << x.size); i++) begin
            mem_m[off+i] = x.wdata[8*((off+i)%4) +: 8];
        end
    endtask

    task automatic push(input logic [1:0] tr, input logic [31:0] a, input logic wr,
                        input logic [2:0] sz, input logic [31:0] wd);
        xfer_t x;
        x.trans = tr;
        x.addr  = a;
        x.write = wr;
        x.size  = sz;
        x.wdata = wd;
        q.push_back(x);
    endtask

    // One bus cycle; entered and left at posedge+1.
    task automatic step();
        xfer_t       a;
        bit          a_valid;
        bit          exp_ready;
        logic        exp_resp;
        logic [31:0] exp_rdata;
        a_valid = (q.size() > 0);
        if (a_valid) begin
            a = q[0];
            htrans = a.trans;
            haddr  = a.addr;
            hwrite = a.write;
            hsize  = a.size;
        end else begin
            htrans = HASTI_TRANS_IDLE;
            haddr  = $urandom;
            hwrite = 1'($urandom);
            hsize  = 3'($urandom);
        end
        hburst    = 3'($urandom);
        hprot     = 4'($urandom);
        hmastlock = 1'($urandom);
        hwdata    = (p_valid && p.write) ? p.wdata : $urandom;
        exp_ready = !p_valid || p_left == 1;
        exp_resp  = p_valid && p_bad;
        exp_rdata = (p_valid && !p_bad && !p.write && exp_ready) ? word_of(p.addr) : 32'h0;
        @(negedge clk);
        check_val($sformatf("hready@%0d", cyc), {31'b0, hready}, {31'b0, exp_ready});
        check_val($sformatf("hresp@%0d", cyc), {31'b0, hresp}, {31'b0, exp_resp});
        check_val($sformatf("hrdata@%0d", cyc), hrdata, exp_rdata);
        if (p_valid) begin
            if (exp_ready) begin
                if (!p_bad && p.write) apply_write(p);
                p_valid = 1'b0;
            end else begin
                p_left--;
            end
        end
        if (exp_ready && a_valid) begin
            void'(q.pop_front());
            if (a.trans[1]) begin
                p       = a;
                p_valid = 1'b1;
                p_bad   = is_bad(a);
                p_left  = p_bad ? 2 : int'(WAITS) + 1;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_all();
        int budget = 4000;
        while ((q.size() > 0 || p_valid) && budget > 0) begin
            step();
            budget--;
        end
        check_val("drain_budget", {31'b0, budget == 0}, 32'h0);
    endtask

    // Accept one transfer, then reset partway through its data phase.
    task automatic reset_mid(input logic [31:0] a, input logic wr, input logic [31:0] wd);
        push(HASTI_TRANS_NONSEQ, a, wr, 3'd2, wd);
        step();
        htrans = HASTI_TRANS_IDLE;
        hwdata = wd;
        #2;
        reset_n = 1'b0;
        #1;
        check_val("rst_mid_hready", {31'b0, hready}, 32'h1);
        check_val("rst_mid_hresp", {31'b0, hresp}, 32'h0);
        check_val("rst_mid_hrdata", hrdata, 32'h0);
        p_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        push(HASTI_TRANS_NONSEQ, a, 1'b0, 3'd2, 32'h0);
        run_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        logic [1:0]  tr;
        int          r;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        p_valid  = 1'b0;

        #1 reset_n = 1'b0;
        @(negedge clk);
        check_val("reset_hready", {31'b0, hready}, 32'h1);
        check_val("reset_hresp", {31'b0, hresp}, 32'h0);
        check_val("reset_hrdata", hrdata, 32'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int w = 0; w < int'(NWORDS); w++) begin
            push(HASTI_TRANS_NONSEQ, BASE + 32'(4 * w), 1'b1, 3'd2, $urandom);
        end
        run_all();

        // Word write then read.
        push(HASTI_TRANS_NONSEQ, BASE + 32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF);
        push(HASTI_TRANS_NONSEQ, BASE + 32'h10, 1'b0, 3'd2, 32'h0);
        run_all();
        check_val("model_deadbeef", word_of(BASE + 32'h10), 32'hDEAD_BEEF);

        // Byte and half writes over a zeroed word.
        push(HASTI_TRANS_NONSEQ, BASE + 32'h10, 1'b1, 3'd2, 32'h0);
        push(HASTI_TRANS_NONSEQ, BASE + 32'h11, 1'b1, 3'd0, 32'h0000_AA00);
        push(HASTI_TRANS_NONSEQ, BASE + 32'h10, 1'b0, 3'd2, 32'h0);
        push(HASTI_TRANS_NONSEQ, BASE + 32'h12, 1'b1, 3'd1, 32'h1234_0000);
        push(HASTI_TRANS_NONSEQ, BASE + 32'h10, 1'b0, 3'd2, 32'h0);
        run_all();
        check_val("model_sub_word", word_of(BASE + 32'h10), 32'h1234_AA00);

        // Read with the next NONSEQ already waiting on the bus.
        push(HASTI_TRANS_NONSEQ, BASE + 32'h10, 1'b0, 3'd2, 32'h0);
        push(HASTI_TRANS_SEQ, BASE + 32'h14, 1'b0, 3'd2, 32'h0);
        push(HASTI_TRANS_IDLE, BASE, 1'b0, 3'd2, 32'h0);
        run_all();

        // Error cases; the array must stay unchanged.
        push(HASTI_TRANS_NONSEQ, BASE + 32'h2, 1'b0, 3'd2, 32'h0);
        push(HASTI_TRANS_NONSEQ, BASE + 32'(NBYTES), 1'b0, 3'd2, 32'h0);
        push(HASTI_TRANS_NONSEQ, BASE + 32'h11, 1'b1, 3'd1, 32'hFFFF_FFFF);
        push(HASTI_TRANS_NONSEQ, BASE + 32'h10, 1'b1, 3'd3, 32'hFFFF_FFFF);
        push(HASTI_TRANS_NONSEQ, BASE - 32'h4, 1'b1, 3'd2, 32'hFFFF_FFFF);
        push(HASTI_TRANS_NONSEQ, BASE + 32'h10, 1'b0, 3'd2, 32'h0);
        run_all();

        // Back-to-back writes then reads.
        push(HASTI_TRANS_NONSEQ, BASE + 32'h0, 1'b1, 3'd2, 32'h1111_2222);
        push(HASTI_TRANS_SEQ, BASE + 32'h4, 1'b1, 3'd2, 32'h3333_4444);
        push(HASTI_TRANS_NONSEQ, BASE + 32'h0, 1'b0, 3'd2, 32'h0);
        push(HASTI_TRANS_SEQ, BASE + 32'h4, 1'b0, 3'd2, 32'h0);
        run_all();

        reset_mid(BASE + 32'h20, 1'b1, 32'hCAFE_F00D);
        reset_mid(BASE + 32'h24, 1'b0, 32'h0);

        for (int n = 0; n < 400; n++) begin
            r  = int'($urandom_range(0, 99));
            tr = (r < 70) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            sz = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7))
                                              : 3'($urandom_range(0, 2));
            a  = BASE + 32'($urandom_range(0, NBYTES - 1));
            if ($urandom_range(0, 9) < 8 && sz <= 3'd2) begin
                a = a & ~((32'h1 << sz) - 32'h1);
            end
            r = int'($urandom_range(0, 99));
            if (r < 4) a = BASE + 32'(NBYTES) + 32'($urandom_range(0, 8));
            else if (r < 8) a = BASE - 32'($urandom_range(1, 8));
            push(tr, a, 1'($urandom), sz, $urandom);
            if (q.size() >= 8) run_all();
        end
        run_all();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vscale_hasti_sram_slave.md
# vscale_hasti_sram_slave

HASTI (AHB-lite) single-port SRAM responder for the core's imem or dmem master port. Decodes address phases from one master, inserts configurable wait states, performs byte/half/word reads and writes, and returns OKAY or a two-cycle ERROR. Sits between `vscale_core` and the testbench/SoC memory map, one instance per core bus.

## Interface
- `NWORDS`, 1024: depth in 32-bit words; power of two.
- `BASE_ADDR`, 32'h0: byte address of word 0; aligned to `NWORDS*4`.
- `WAIT_STATES`, 0: data-phase wait cycles per OKAY transfer, 0..15; honoured only with the macro.

- `clk` in 1: clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `haddr` in `HASTI_ADDR_WIDTH` (32): address-phase byte address.
- `hwrite` in 1: 1 = write.
- `hsize` in `HASTI_SIZE_WIDTH` (3): 0 byte, 1 half, 2 word; others are errors.
- `hburst` in `HASTI_BURST_WIDTH`, `hmastlock` in 1, `hprot` in `HASTI_PROT_WIDTH`: accepted, ignored.
- `htrans` in `HASTI_TRANS_WIDTH` (2): IDLE/BUSY/NONSEQ/SEQ.
- `hwdata` in `HASTI_BUS_WIDTH` (32): write data, data phase, natural byte lanes.
- `hrdata` out 32: read data; full word, valid when `hready`=1 in a read data phase, else 0.
- `hready` out 1: transfer-done / bus ready.
- `hresp` out `HASTI_RESP_WIDTH` (1): 0 OKAY, 1 ERROR.

## Operation
- Address phase accepted when `hready`=1 and `htrans` is NONSEQ or SEQ; latch `haddr`, `hwrite`, `hsize` for the data phase. IDLE/BUSY: no data phase; next cycle is zero-wait OKAY.
- Error check at accept: `haddr` outside [`BASE_ADDR`, `BASE_ADDR+4*NWORDS`), `hsize`>2, half with `haddr[0]`=1, word with `haddr[1:0]`≠0.
- States: `IDLE` (no data phase), `DATA` (OKAY data phase, counting waits), `ERR1`, `ERR2`.
  - `IDLE`/final `DATA` cycle + accepted good transfer -> `DATA`, counter = `WAIT_STATES`.
  - accepted bad transfer -> `ERR1`; `ERR1` -> `ERR2` unconditionally; `ERR2` behaves as a completing cycle (may accept next address phase).
  - `DATA` with counter>0: `hready`=0, decrement; counter=0: `hready`=1, transfer completes.
- Outputs: `IDLE` hready=1 hresp=0; `DATA` hready=(cnt==0) hresp=0; `ERR1` hready=0 hresp=1; `ERR2` hready=1 hresp=1.
- Write commits at the clock edge ending the completing `DATA` cycle; byte enables: byte -> lane `addr[1:0]`, half -> lanes `{addr[1],0}`+1, word -> all 4. Errored transfers never write.
- Read: `hrdata` = array[latched word index] combinationally while in `DATA`; a read directly following a write to the same word returns the new data.
- Word index = `(addr - BASE_ADDR) >> 2`, truncated to `$clog2(NWORDS)` bits.
- Reset: state `IDLE`, counter 0, latched phase cleared, hready=1, hresp=0, hrdata=0; in-flight transfer dropped without write; array contents not cleared.

## Timing
- Zero-wait read/write: address phase cycle N, data/response cycle N+1 (`hready`=1).
- Wait-state transfer: response cycle N+1+`WAIT_STATES`; master's next address held stable and sampled only then.
- Error: `hready`=0 cycle N+1, `hready`=1 cycle N+2, hresp=1 both.
- Back-to-back pipelined transfers: one per cycle at zero wait.

## Configuration
- `VSCALE_HASTI_SRAM_WAIT_EN` defined: `WAIT_STATES` honoured, 4-bit wait counter present.
- Undefined: counter removed, `DATA` always completes in one cycle, `WAIT_STATES` ignored.

## Structure
- HTRANS/HSIZE/HRESP codes and bus widths from `vscale_hasti_constants.vh`; add `HASTI_TRANS_*` and `HASTI_RESP_*` there if absent. State encoding local.
- One sub-module `vscale_sram_array`: `NWORDS`x32 storage, combinational read, 4-bit byte-enable synchronous write.

## Test plan
- Word write 0xDEADBEEF @0x10 then read @0x10, WAIT_STATES=0 -> hready=1 each data cycle, hrdata=0xDEADBEEF, hresp=0.
- Byte write 0xAA @0x11 over word 0x00000000, then word read @0x10 -> 0x0000AA00; half write 0x1234 @0x12 -> 0x1234AA00.
- Macro on, WAIT_STATES=2, read -> hready low 2 cycles, high on 3rd with data; next NONSEQ held during wait is accepted only then.
- Word read @0x2 (misaligned) and @`BASE_ADDR+4*NWORDS` -> hready 0/1, hresp 1/1; array unchanged.
- Back-to-back writes @0x0,0x4 then reads, zero wait -> one completion per cycle, correct data.
- reset_n low during a waited write -> outputs hready=1 hresp=0 hrdata=0 immediately; target word unchanged.
